if_id_skid_reg: RTL and testbench
=================================

Name: if_id_skid_reg

Overview:
- Parametrised IF/ID pipeline stage between the fetch unit and the decoder.
- Carries a fetch bundle of LANES instructions plus PC and fault flag.
- Uses a valid/ready handshake backed by a 2-entry skid buffer, so the stage sustains 1 bundle/cycle and in_ready is fully registered.
- Flush drops all held bundles and presents NOP bubbles downstream.

Parameters:
- XLEN, 32, PC width in bits
- LANES, 1, instructions per fetch bundle (1..4)
- NOP_INSN, 32'h00000013, bubble encoding driven on every lane when the stage holds no valid bundle
- RESET_PC, 32'h00000000, value of out_pc after reset

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  control-hazard kill; discards both buffer entries
- in_valid  in  1  fetch bundle present
- in_ready  out  1  stage can accept a bundle (registered)
- in_pc  in  XLEN  PC of lane 0
- in_ir  in  32*LANES  instructions; lane k occupies bits [32k+31:32k]
- in_mask  in  LANES  per-lane valid bits
- in_fault  in  1  instruction-fetch access fault
- out_valid  out  1  bundle presented to decode
- out_ready  in  1  decode accepts the bundle
- out_pc  out  XLEN
- out_ir  out  32*LANES
- out_mask  out  LANES
- out_fault  out  1

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: out_valid=0, out_ir=NOP_INSN on all lanes, out_mask=0, out_fault=0, out_pc=RESET_PC, in_ready=1, both entries empty.
- Storage: entry M (main, drives outputs) and entry S (skid). FIFO order is always preserved; S is never occupied while M is empty.
- Transfers: accept = in_valid & in_ready; retire = out_valid & out_ready.
- Empty stage, accept: bundle lands in M; out_valid=1 the next cycle (latency 1).
- M full, retire and accept together: the new bundle replaces M. Throughput is 1/cycle.
- M full, no retire, accept: bundle goes to S; in_ready=0 the next cycle.
- S full, retire: S moves to M; in_ready=1 the next cycle.
- in_ready is registered as the complement of "S full", computed from next state. It must not combinationally depend on out_ready.
- Flush: the next cycle has both entries empty, out_valid=0, out_ir=NOP on all lanes, out_mask=0, out_fault=0, in_ready=1.
  - out_pc loads in_pc if in_valid, otherwise it holds.
  - During a flush cycle no accept occurs: in_valid is ignored for the handshake, and a retire is still counted as completed by the decoder.
- Priority: rst > flush > normal handshake.
- Payload width: out_ir, out_mask and out_fault hold their value while out_valid=1 and out_ready=0.
- When out_valid=0: out_ir lanes read NOP_INSN and out_mask reads 0, whatever stale data is stored.
- Masked lanes (in_mask[k]=0) are stored as NOP_INSN, not as the raw in_ir data.
- Reset mid-stall discards all content, including S.

Optional Feature:
- Macro: IF_ID_SKID_PERF_EN.
- Defined: adds outputs stall_cnt[31:0] and bubble_cnt[31:0].
  - stall_cnt increments on each cycle with out_valid & ~out_ready.
  - bubble_cnt increments on each cycle with out_valid=0.
  - Both counters wrap at 2^32 and clear on rst or flush-free reset only (flush does not clear them).
- Not defined: neither port nor counter logic exists; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg:
  - NOP_INSN constant (32'h00000013) and RESET_PC default.
  - typedef fetch_bundle_t {pc, ir[LANES], mask, fault}.
  - Lane-width constant ILEN=32.
- Natural sub-module skid_buf2: generic 2-entry valid/ready skid buffer over a packed payload width, with a flush input.
- The top level does payload packing, NOP substitution, reset values and the perf counters.

Test Plan:
- Reset, then one bundle in_pc=0x100, in_ir=0x00500093 (LANES=1) with out_ready=1 -> next cycle out_valid=1, out_pc=0x100, out_ir=0x00500093; in_ready stays 1.
- Stream of 8 bundles with out_ready held 1 -> one retire per cycle, PCs 0x100..0x11C in order, in_ready never drops.
- out_ready=0 while 2 bundles enter (0x200, 0x204) -> in_ready=0 after the second; raise out_ready -> 0x200 then 0x204 retire, in_ready returns to 1 one cycle after S drains.
- Both entries full, assert flush with in_valid=1, in_pc=0x300 -> next cycle out_valid=0, out_ir=0x00000013, out_pc=0x300, in_ready=1, and neither held bundle ever appears.
- LANES=2, in_mask=2'b01, in_ir={0xDEADBEEF,0x00100113} -> out_ir upper lane=0x00000013, lower lane=0x00100113, out_mask=2'b01.
- With IF_ID_SKID_PERF_EN, hold out_ready=0 for 5 cycles with M full -> stall_cnt=5; rst mid-stall -> all outputs at reset values and the counters read 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared IF/ID pipeline constants and lane helpers.
package pipe_pkg;

  localparam int          ILEN         = 32;
  localparam logic [31:0] DEF_NOP_INSN = 32'h00000013;
  localparam logic [31:0] DEF_RESET_PC = 32'h00000000;

  function automatic logic [ILEN-1:0] lane_or_nop(input logic            lane_vld,
                                                  input logic [ILEN-1:0] insn,
                                                  input logic [ILEN-1:0] nop);
    return lane_vld ? insn : nop;
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// Generic 2-entry valid/ready skid buffer with registered in_ready and flush.
// On flush both entries are dropped; M data captures in_data when in_valid so a redirect target is visible.
module skid_buf2 #(
  parameter int           W        = 8,
  parameter logic [W-1:0] RST_DATA = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         m_vld_q, m_vld_d;
  logic         s_vld_q, s_vld_d;
  logic         rdy_q;
  logic [W-1:0] m_q, m_d;
  logic [W-1:0] s_q, s_d;
  logic         accept, retire;

  always_comb begin
    accept  = in_valid & rdy_q & ~flush;
    retire  = m_vld_q & out_ready;
    m_vld_d = m_vld_q;
    s_vld_d = s_vld_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush) begin
      m_vld_d = 1'b0;
      s_vld_d = 1'b0;
      if (in_valid) m_d = in_data;
    end else if (s_vld_q) begin
      if (retire) begin
        m_d     = s_q;
        s_vld_d = 1'b0;
      end
    end else if (m_vld_q) begin
      if (retire && accept) begin
        m_d = in_data;
      end else if (retire) begin
        m_vld_d = 1'b0;
      end else if (accept) begin
        s_d     = in_data;
        s_vld_d = 1'b1;
      end
    end else if (accept) begin
      m_d     = in_data;
      m_vld_d = 1'b1;
    end
  end

  // in_ready is the registered complement of the next-state skid occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      m_vld_q <= 1'b0;
      s_vld_q <= 1'b0;
      rdy_q   <= 1'b1;
      m_q     <= RST_DATA;
    end else begin
      m_vld_q <= m_vld_d;
      s_vld_q <= s_vld_d;
      rdy_q   <= ~s_vld_d;
      m_q     <= m_d;
    end
  end

  always_ff @(posedge clk) begin
    s_q <= s_d;
  end

  assign in_ready  = rdy_q;
  assign out_valid = m_vld_q;
  assign out_data  = m_q;

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID stage: packs the fetch bundle into a 2-entry skid buffer and substitutes NOPs for empty lanes.
// Optional IF_ID_SKID_PERF_EN adds stall_cnt / bubble_cnt performance counters.
module if_id_skid_reg
  import pipe_pkg::*;
#(
  parameter int                XLEN     = 32,
  parameter int                LANES    = 1,
  parameter logic [ILEN-1:0]   NOP_INSN = DEF_NOP_INSN,
  parameter logic [XLEN-1:0]   RESET_PC = XLEN'(DEF_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [ILEN*LANES-1:0] in_ir,
  input  logic [LANES-1:0]      in_mask,
  input  logic                  in_fault,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_pc,
  output logic [ILEN*LANES-1:0] out_ir,
  output logic [LANES-1:0]      out_mask,
  output logic                  out_fault
`ifdef IF_ID_SKID_PERF_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           bubble_cnt
`endif
);

  typedef struct packed {
    logic [XLEN-1:0]            pc;
    logic [LANES-1:0][ILEN-1:0] ir;
    logic [LANES-1:0]           mask;
    logic                       fault;
  } fetch_bundle_t;

  localparam int BW = $bits(fetch_bundle_t);
  localparam logic [BW-1:0] RST_DATA = {RESET_PC, {LANES{NOP_INSN}}, {LANES{1'b0}}, 1'b0};

  fetch_bundle_t in_b, out_b;
  logic [BW-1:0] buf_data;
  logic          buf_vld;

  always_comb begin
    in_b.pc    = in_pc;
    in_b.mask  = in_mask;
    in_b.fault = in_fault;
    for (int k = 0; k < LANES; k++) begin
      in_b.ir[k] = lane_or_nop(in_mask[k], in_ir[k*ILEN +: ILEN], NOP_INSN);
    end
  end

  skid_buf2 #(
    .W        (BW),
    .RST_DATA (RST_DATA)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_b),
    .out_valid (buf_vld),
    .out_ready (out_ready),
    .out_data  (buf_data)
  );

  assign out_b = buf_data;

  // Stale payload stays hidden behind NOP/zero whenever no bundle is presented
  always_comb begin
    out_valid = buf_vld;
    out_pc    = out_b.pc;
    out_mask  = buf_vld ? out_b.mask : '0;
    out_fault = buf_vld & out_b.fault;
    for (int k = 0; k < LANES; k++) begin
      out_ir[k*ILEN +: ILEN] = lane_or_nop(buf_vld, out_b.ir[k], NOP_INSN);
    end
  end

`ifdef IF_ID_SKID_PERF_EN
  logic [31:0] stall_cnt_q, bubble_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else if (!buf_vld) begin
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end else if (!out_ready) begin
      stall_cnt_q  <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Bench for if_id_skid_reg (LANES=2): directed literal checks plus randomized traffic against a queue model.
module tb_if_id_skid_reg;

  localparam int          LANES = 2;
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [63:0] NOP2  = {NOP, NOP};

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_fault;
  logic [31:0] in_pc, out_pc;
  logic [63:0] in_ir, out_ir;
  logic [1:0]  in_mask, out_mask;
  logic        out_valid, out_ready, out_fault;
`ifdef IF_ID_SKID_PERF_EN
  logic [31:0] stall_cnt, bubble_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  if_id_skid_reg #(
    .XLEN     (32),
    .LANES    (LANES),
    .NOP_INSN (NOP),
    .RESET_PC (32'h0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_ir     (in_ir),
    .in_mask   (in_mask),
    .in_fault  (in_fault),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_ir    (out_ir),
    .out_mask  (out_mask),
    .out_fault (out_fault)
`ifdef IF_ID_SKID_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: an ordered queue of at most two bundles
  typedef struct {
    logic [31:0] pc;
    logic [63:0] ir;
    logic [1:0]  mask;
    logic        fault;
  } mb_t;

  mb_t         mq[$];
  mb_t         nb;
  logic [31:0] m_pc;
  logic        m_rdy;
  logic [31:0] m_stall, m_bub;
  bit          m_ok = 0;
  bit          acc;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_pc    = 32'h0;
      m_rdy   = 1'b1;
      m_stall = 0;
      m_bub   = 0;
      m_ok    = 1;
    end else if (m_ok) begin
      if (mq.size() == 0) m_bub = m_bub + 1;
      else if (!out_ready) m_stall = m_stall + 1;
      if (flush) begin
        mq.delete();
        if (in_valid) m_pc = in_pc;
        m_rdy = 1'b1;
      end else begin
        acc = in_valid && m_rdy;
        if (mq.size() > 0 && out_ready) void'(mq.pop_front());
        if (acc) begin
          nb.pc    = in_pc;
          nb.mask  = in_mask;
          nb.fault = in_fault;
          for (int k = 0; k < LANES; k++)
            nb.ir[k*32 +: 32] = in_mask[k] ? in_ir[k*32 +: 32] : NOP;
          mq.push_back(nb);
        end
        if (mq.size() > 0) m_pc = mq[0].pc;
        m_rdy = (mq.size() < 2);
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      logic mv;
      mv = (mq.size() > 0);
      chk("m_out_valid", 64'(out_valid), 64'(mv));
      chk("m_in_ready",  64'(in_ready),  64'(m_rdy));
      chk("m_out_pc",    64'(out_pc),    64'(m_pc));
      chk("m_out_ir",    out_ir,         mv ? mq[0].ir : NOP2);
      chk("m_out_mask",  64'(out_mask),  mv ? 64'(mq[0].mask) : 64'd0);
      chk("m_out_fault", 64'(out_fault), mv ? 64'(mq[0].fault) : 64'd0);
`ifdef IF_ID_SKID_PERF_EN
      chk("m_stall_cnt",  64'(stall_cnt),  64'(m_stall));
      chk("m_bubble_cnt", 64'(bubble_cnt), 64'(m_bub));
`endif
    end
  end

  // ---------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [31:0] pc, input logic [63:0] ir,
                     input logic [1:0] mk, input logic ordy);
    in_valid  = v;
    in_pc     = pc;
    in_ir     = ir;
    in_mask   = mk;
    in_fault  = 1'b0;
    out_ready = ordy;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    drv(1'b0, 32'h0, 64'h0, 2'b00, 1'b0);
    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc",    64'(out_pc),    64'h0);
    chk("rst_out_ir",    out_ir,         NOP2);
    chk("rst_out_mask",  64'(out_mask),  64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    rst = 1'b0;

    drv(1'b1, 32'h100, {32'h11111111, 32'h00500093}, 2'b01, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("first_valid", 64'(out_valid), 64'd1);
    chk("first_pc",    64'(out_pc),    64'h100);
    chk("first_ir",    out_ir,         {NOP, 32'h00500093});
    chk("first_rdy",   64'(in_ready),  64'd1);

    for (int i = 0; i < 8; i++) begin
      drv(1'b1, 32'h100 + 32'(4*i), {32'(i), 32'h00000093 + 32'(i)}, 2'b11, 1'b1);
      tick();
      chk("stream_pc",  64'(out_pc),   64'(32'h100 + 32'(4*i)));
      chk("stream_rdy", 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain", 64'(out_valid), 64'd0);

    drv(1'b1, 32'h200, 64'h1, 2'b11, 1'b0);
    tick();
    chk("skid_a_rdy", 64'(in_ready), 64'd1);
    drv(1'b1, 32'h204, 64'h2, 2'b11, 1'b0);
    tick();
    chk("skid_full_rdy", 64'(in_ready), 64'd0);
    chk("skid_full_pc",  64'(out_pc),   64'h200);
    drv(1'b0, 32'h0, 64'h0, 2'b00, 1'b1);
    tick();
    chk("skid_b_pc",  64'(out_pc),    64'h204);
    chk("skid_b_vld", 64'(out_valid), 64'd1);
    chk("skid_b_rdy", 64'(in_ready),  64'd1);
    tick();
    chk("skid_empty", 64'(out_valid), 64'd0);

    drv(1'b1, 32'h400, 64'h4, 2'b11, 1'b0);
    tick();
    drv(1'b1, 32'h404, 64'h5, 2'b11, 1'b0);
    tick();
    chk("preflush_rdy", 64'(in_ready), 64'd0);
    flush = 1'b1;
    drv(1'b1, 32'h300, 64'h6, 2'b11, 1'b0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_vld",  64'(out_valid), 64'd0);
    chk("flush_ir",   out_ir,         NOP2);
    chk("flush_pc",   64'(out_pc),    64'h300);
    chk("flush_rdy",  64'(in_ready),  64'd1);
    chk("flush_mask", 64'(out_mask),  64'd0);
    out_ready = 1'b1;
    tick();
    chk("flush_gone1", 64'(out_valid), 64'd0);
    tick();
    chk("flush_gone2", 64'(out_valid), 64'd0);

    drv(1'b1, 32'h600, {32'hDEADBEEF, 32'h00100113}, 2'b01, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("mask_ir",   out_ir,          {NOP, 32'h00100113});
    chk("mask_mask", 64'(out_mask),   64'h1);
    tick();

    rst = 1'b1;
    tick();
    rst = 1'b0;
    drv(1'b1, 32'h500, 64'h7, 2'b11, 1'b0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
`ifdef IF_ID_SKID_PERF_EN
    chk("perf_stall5",  64'(stall_cnt),  64'd5);
    chk("perf_bubble1", 64'(bubble_cnt), 64'd1);
`endif
    drv(1'b1, 32'h504, 64'h8, 2'b11, 1'b0);
    tick();
    chk("stall_full_rdy", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_vld", 64'(out_valid), 64'd0);
    chk("midrst_pc",  64'(out_pc),    64'h0);
    chk("midrst_ir",  out_ir,         NOP2);
    chk("midrst_rdy", 64'(in_ready),  64'd1);
`ifdef IF_ID_SKID_PERF_EN
    chk("midrst_stall",  64'(stall_cnt),  64'd0);
    chk("midrst_bubble", 64'(bubble_cnt), 64'd0);
`endif
    out_ready = 1'b1;
    tick();
    chk("midrst_no_s", 64'(out_valid), 64'd0);

    for (int i = 0; i < 2500; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_pc     = $urandom;
      in_ir     = {$urandom, $urandom};
      in_mask   = 2'($urandom_range(0, 3));
      in_fault  = 1'($urandom_range(0, 1));
      tick();
    end
    rst = 1'b0;
    flush = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
